digital_clock: RTL and testbench
================================

Name: digital_clock

Overview:
- 24-hour hours/minutes/seconds clock driven by a 1 Hz tick.
- Keeps six BCD digits (HH:MM:SS) and drives each as a 7-segment pattern.
- Each field is a 14-bit bus: tens digit on [13:7], ones digit on [6:0].
- Sits between the timebase and the display drivers; at the default parameter, clk is the 1 Hz tick itself.

Parameters:
- TICKS_PER_SEC, default 1: clk rising edges per one-second advance. Internal prescaler counts 0..TICKS_PER_SEC-1. Legal range 1..2^24.

Ports:
- clk, input, 1: rising-edge clock; 1 Hz at default TICKS_PER_SEC.
- reset, input, 1: asynchronous, active-low reset.
- secCode, output, 14: seconds; [13:7] tens pattern, [6:0] ones pattern.
- minCode, output, 14: minutes; same layout.
- hrsCode, output, 14: hours; same layout.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- While reset=0: all digits and the prescaler clear immediately (no clk edge needed), giving 00:00:00.
  - Reset values: secCode = minCode = hrsCode = {7'b1111110, 7'b1111110}, i.e. 14'h3F7E.
- First advance after reset release: the TICKS_PER_SEC-th rising clk edge.
- State: six BCD registers.
  - sec_ones 0-9, sec_tens 0-5
  - min_ones 0-9, min_tens 0-5
  - hr_ones 0-9, hr_tens 0-2
  - Plus prescaler count.
- One-second advance (prescaler wraps to 0), on the same edge:
  - sec_ones +1; at 9 wraps to 0 and carries to sec_tens.
  - sec_tens at 5 with carry-in wraps to 0 and carries to minutes (59 -> 00).
  - Minutes count identically; a carry out of 59 goes to hours.
  - Hours count 00..23. At 23 with carry-in, both hour digits go to 0. hr_ones wraps 9 -> 0 with tens +1 (09 -> 10, 19 -> 20).
  - 23:59:59 + 1 s = 00:00:00, all six digits updating on one edge.
- Without a one-second advance, all digits hold.
- Decode: outputs are combinational 7-segment decode of the registered digits, so they change after the same clk edge as the counters. No extra latency.
- Segment order, bit 6..0 = a,b,c,d,e,f,g. Active-high: 1 = segment lit.
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
- Unreachable BCD values (10-15) decode to 0000000 (blank). The counters must never produce them.
- Reset asserted mid-count overrides any pending advance. Release takes effect only on later edges, and counting restarts from 00:00:00 with the prescaler at 0.
- No load/set inputs and no outputs other than the three code buses.

Test Plan:
- Reset: hold reset=0 (clk running or stopped) -> all three buses = 14'h3F7E. Assert reset=0 asynchronously between edges -> buses return to 14'h3F7E before the next edge.
- First second: release reset, 1 rising edge -> secCode = {1111110,0110000} (00:00:01). After 9 edges -> secCode ones = 1111011. After 10 edges -> secCode = {0110000,1111110} (10).
- Minute carry: 59 edges -> secCode = {1011011,1111011}. 60th edge -> secCode = 14'h3F7E and minCode = {1111110,0110000} (00:01:00).
- Hour carry and 09->10: 3600 edges -> hrsCode = {1111110,0110000}. 36000 edges -> hrsCode = {0110000,1111110}, min/sec both 14'h3F7E.
- Day wrap: 86399 edges -> hrsCode = {1101101,1111001}, minCode = secCode = {1011011,1111011} (23:59:59). Next edge -> all three = 14'h3F7E.
- Prescaler: TICKS_PER_SEC=4 -> secCode unchanged after 3 edges, ones = 0110000 after the 4th. Reset mid-prescale restarts the 4-edge count.

Source files
------------

// File: rtl/digital_clock.sv
// 24-hour HH:MM:SS clock advanced once per TICKS_PER_SEC clk edges.
// Six BCD digit registers, each decoded combinationally to an active-high a..g segment pattern.
module digital_clock #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] secCode,
  output logic [13:0] minCode,
  output logic [13:0] hrsCode
);

  localparam logic [23:0] PRE_MAX = 24'(TICKS_PER_SEC - 1);

  logic [23:0] pre_cnt;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic        tick;
  logic        sec_ones_wrap, sec_tens_wrap, min_ones_wrap, min_tens_wrap;
  logic        hr_ones_wrap, day_wrap;

  // Each wrap flag means "this digit rolls over on this edge" and is the carry-in of the next digit.
  assign tick          = (pre_cnt == PRE_MAX);
  assign sec_ones_wrap = tick && (sec_ones == 4'd9);
  assign sec_tens_wrap = sec_ones_wrap && (sec_tens == 4'd5);
  assign min_ones_wrap = sec_tens_wrap && (min_ones == 4'd9);
  assign min_tens_wrap = min_ones_wrap && (min_tens == 4'd5);
  assign day_wrap      = min_tens_wrap && (hr_tens == 4'd2) && (hr_ones == 4'd3);
  assign hr_ones_wrap  = min_tens_wrap && (hr_ones == 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt  <= '0;
      sec_ones <= '0;
      sec_tens <= '0;
      min_ones <= '0;
      min_tens <= '0;
      hr_ones  <= '0;
      hr_tens  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 24'd1;
      if (tick)
        sec_ones <= sec_ones_wrap ? 4'd0 : sec_ones + 4'd1;
      if (sec_ones_wrap)
        sec_tens <= sec_tens_wrap ? 4'd0 : sec_tens + 4'd1;
      if (sec_tens_wrap)
        min_ones <= min_ones_wrap ? 4'd0 : min_ones + 4'd1;
      if (min_ones_wrap)
        min_tens <= min_tens_wrap ? 4'd0 : min_tens + 4'd1;
      if (day_wrap) begin
        hr_ones <= 4'd0;
        hr_tens <= 4'd0;
      end else if (min_tens_wrap) begin
        hr_ones <= hr_ones_wrap ? 4'd0 : hr_ones + 4'd1;
        if (hr_ones_wrap)
          hr_tens <= hr_tens + 4'd1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign secCode = {seg7(sec_tens), seg7(sec_ones)};
  assign minCode = {seg7(min_tens), seg7(min_ones)};
  assign hrsCode = {seg7(hr_tens), seg7(hr_ones)};

endmodule

// File: tb/tb_digital_clock.sv
// Directed bench: one clock at TICKS_PER_SEC=1 walked through a full day,
// plus a TICKS_PER_SEC=4 instance for prescaler and mid-prescale reset.
module tb_digital_clock;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [13:0] ZZ = 14'h3F7E;

  logic        clk;
  logic        rst1, rst4;
  logic [13:0] sec1, min1, hrs1;
  logic [13:0] sec4, min4, hrs4;

  int checks = 0;
  int errors = 0;
  int cnt1   = 0;

  digital_clock #(.TICKS_PER_SEC(1)) u_dut (
    .clk(clk), .reset(rst1), .secCode(sec1), .minCode(min1), .hrsCode(hrs1)
  );

  digital_clock #(.TICKS_PER_SEC(4)) u_dut4 (
    .clk(clk), .reset(rst4), .secCode(sec4), .minCode(min4), .hrsCode(hrs4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance the 1 Hz instance until cnt1 seconds have elapsed since its reset release.
  task automatic goto1(input int target);
    while (cnt1 < target) begin
      @(negedge clk);
      cnt1++;
    end
  endtask

  initial begin
    rst1 = 1'b0;
    rst4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sec",  sec1, ZZ);
    chk("rst_min",  min1, ZZ);
    chk("rst_hrs",  hrs1, ZZ);
    chk("rst4_sec", sec4, ZZ);

    // Prescaler: four edges per second; rst1 stays low meanwhile.
    rst4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_3edges", sec4, ZZ);
    @(negedge clk);
    chk("pre_4edges", sec4, {S0, S1});
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst4 = 1'b0;
    #1 chk("pre_async_rst", sec4, ZZ);
    @(negedge clk);
    rst4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_restart_3", sec4, ZZ);
    @(negedge clk);
    chk("pre_restart_4", sec4, {S0, S1});
    chk("held_rst_sec", sec1, ZZ);

    rst1 = 1'b1;
    cnt1 = 0;
    goto1(1);
    chk("s01", sec1, {S0, S1});
    chk("s01_min", min1, ZZ);
    goto1(9);
    chk("s09", sec1, {S0, S9});
    goto1(10);
    chk("s10", sec1, {S1, S0});
    goto1(59);
    chk("s59", sec1, {S5, S9});
    chk("s59_min", min1, ZZ);
    goto1(60);
    chk("m01_sec", sec1, ZZ);
    chk("m01_min", min1, {S0, S1});

    // Async reset between edges, then restart from 00:00:00.
    @(posedge clk);
    #2 rst1 = 1'b0;
    #1 chk("async_sec", sec1, ZZ);
    chk("async_min", min1, ZZ);
    @(negedge clk);
    rst1 = 1'b1;
    cnt1 = 0;
    goto1(1);
    chk("restart_s01", sec1, {S0, S1});
    chk("restart_min", min1, ZZ);

    goto1(3599);
    chk("h0_5959_hrs", hrs1, ZZ);
    chk("h0_5959_min", min1, {S5, S9});
    goto1(3600);
    chk("h01_hrs", hrs1, {S0, S1});
    chk("h01_min", min1, ZZ);
    chk("h01_sec", sec1, ZZ);
    goto1(35999);
    chk("h09_hrs", hrs1, {S0, S9});
    goto1(36000);
    chk("h10_hrs", hrs1, {S1, S0});
    chk("h10_min", min1, ZZ);
    chk("h10_sec", sec1, ZZ);
    goto1(72000);
    chk("h20_hrs", hrs1, {S2, S0});
    goto1(86399);
    chk("d_hrs", hrs1, {S2, S3});
    chk("d_min", min1, {S5, S9});
    chk("d_sec", sec1, {S5, S9});
    goto1(86400);
    chk("wrap_hrs", hrs1, ZZ);
    chk("wrap_min", min1, ZZ);
    chk("wrap_sec", sec1, ZZ);
    goto1(86401);
    chk("wrap_s01", sec1, {S0, S1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
